// File: rtl/seq_divider_16by8.sv
// Multi-cycle radix-2 restoring divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient/remainder.
// Unsigned or two's-complement operands selected by div_sel; fixed 17-edge latency per operation.
module seq_divider_16by8 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        div_sel,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic [7:0]  quotient,
   output logic [7:0]  remainder,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        div_by_zero,
   output logic        negative,
   output logic        zero
);

   localparam int unsigned DW   = 16;
   localparam int unsigned SW   = 8;
   localparam int unsigned ITER = 16;
   localparam int unsigned CW   = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   quo_q, quo_d;
   logic [SW-1:0]   rem_q, rem_d;
   logic [SW-1:0]   dvs_q, dvs_d;
   logic [SW-1:0]   dvd_lo_q, dvd_lo_d;
   logic            sgn_a_q, sgn_a_d;
   logic            sgn_b_q, sgn_b_d;
   logic            sel_q, sel_d;
   logic            dbz_q, dbz_d;

   logic [SW-1:0]   quotient_d, remainder_d;
   logic            busy_d, done_d, overflow_d, div_by_zero_d, negative_d, zero_d;

   // restoring step signals
   logic [SW:0]     rem_shift;
   logic [SW:0]     diff;
   logic            ge;
   logic [DW-1:0]   step_quo;
   logic [SW-1:0]   step_rem;

   // sign-fix signals
   logic            q_neg;
   logic [DW-1:0]   q_sgn;
   logic [SW-1:0]   r_sgn;
   logic            ovf_raw;
   logic [SW-1:0]   fin_q, fin_r;
   logic            fin_ovf;
   logic [DW-1:0]   dvd_mag;
   logic [SW-1:0]   dvs_mag;
   logic            unused_bits;

   // Partial remainder always stays below the divisor, so the shifted value fits in SW+1 bits.
   always_comb begin
      rem_shift = {rem_q, quo_q[DW-1]};
      diff      = rem_shift - {1'b0, dvs_q};
      ge        = (rem_shift >= {1'b0, dvs_q});
      step_quo  = {quo_q[DW-2:0], ge};
      step_rem  = ge ? diff[SW-1:0] : rem_shift[SW-1:0];
   end

   // Operand magnitudes; -32768 maps onto 16'h8000 which is still a valid unsigned magnitude.
   always_comb begin
      dvd_mag = (div_sel && dividend[DW-1]) ? DW'(~dividend + DW'(1)) : dividend;
      dvs_mag = (div_sel && divisor[SW-1])  ? SW'(~divisor + SW'(1))  : divisor;
   end

   // Sign correction, range check and divide-by-zero override of the final result.
   always_comb begin
      q_neg   = sel_q & (sgn_a_q ^ sgn_b_q);
      q_sgn   = q_neg ? DW'(~quo_q + DW'(1)) : quo_q;
      r_sgn   = (sel_q && sgn_a_q) ? SW'(~rem_q + SW'(1)) : rem_q;
      if (sel_q) begin
         ovf_raw = q_neg ? (quo_q > DW'(128)) : (quo_q > DW'(127));
      end else begin
         ovf_raw = (quo_q > DW'(255));
      end
      if (dbz_q) begin
         fin_q   = '1;
         fin_r   = dvd_lo_q;
         fin_ovf = 1'b0;
      end else begin
         fin_q   = q_sgn[SW-1:0];
         fin_r   = r_sgn;
         fin_ovf = ovf_raw;
      end
   end

   assign unused_bits = &{1'b0, q_sgn[DW-1:SW], diff[SW]};

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         dvd_lo_q    <= '0;
         sgn_a_q     <= 1'b0;
         sgn_b_q     <= 1'b0;
         sel_q       <= 1'b0;
         dbz_q       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
         negative    <= 1'b0;
         zero        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         dvs_q       <= dvs_d;
         dvd_lo_q    <= dvd_lo_d;
         sgn_a_q     <= sgn_a_d;
         sgn_b_q     <= sgn_b_d;
         sel_q       <= sel_d;
         dbz_q       <= dbz_d;
         quotient    <= quotient_d;
         remainder   <= remainder_d;
         busy        <= busy_d;
         done        <= done_d;
         overflow    <= overflow_d;
         div_by_zero <= div_by_zero_d;
         negative    <= negative_d;
         zero        <= zero_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      quo_d         = quo_q;
      rem_d         = rem_q;
      dvs_d         = dvs_q;
      dvd_lo_d      = dvd_lo_q;
      sgn_a_d       = sgn_a_q;
      sgn_b_d       = sgn_b_q;
      sel_d         = sel_q;
      dbz_d         = dbz_q;
      quotient_d    = quotient;
      remainder_d   = remainder;
      busy_d        = busy;
      done_d        = 1'b0;
      overflow_d    = overflow;
      div_by_zero_d = div_by_zero;
      negative_d    = negative;
      zero_d        = zero;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               quo_d    = dvd_mag;
               rem_d    = '0;
               dvs_d    = dvs_mag;
               dvd_lo_d = dividend[SW-1:0];
               sgn_a_d  = div_sel & dividend[DW-1];
               sgn_b_d  = div_sel & divisor[SW-1];
               sel_d    = div_sel;
               dbz_d    = (divisor == '0);
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            quo_d = step_quo;
            rem_d = step_rem;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(ITER - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            quotient_d    = fin_q;
            remainder_d   = fin_r;
            overflow_d    = fin_ovf;
            div_by_zero_d = dbz_q;
            negative_d    = sel_q & fin_q[SW-1];
            zero_d        = (fin_q == '0);
            done_d        = 1'b1;
            busy_d        = 1'b0;
            cnt_d         = '0;
            state_d       = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Scoreboard bench for seq_divider_16by8: directed vectors push expected results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_seq_divider_16by8;

   typedef struct {
      logic [15:0] dvd;
      logic [7:0]  dvs;
      logic        sel;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        ovf;
      logic        dbz;
      logic        neg;
      logic        zro;
      int          acc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        div_sel;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic [7:0]  quotient;
   logic [7:0]  remainder;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        div_by_zero;
   logic        negative;
   logic        zero;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   done_cnt = 0;
   exp_t sb_q[$];
   exp_t vec[$];

   seq_divider_16by8 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .div_sel     (div_sel),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .div_by_zero (div_by_zero),
      .negative    (negative),
      .zero        (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] dvd, input logic [7:0] dvs, input logic sel,
                               input logic [7:0] q, input logic [7:0] r, input logic ovf,
                               input logic dbz, input logic neg, input logic zro);
      exp_t e;
      e.dvd = dvd; e.dvs = dvs; e.sel = sel; e.q = q; e.r = r;
      e.ovf = ovf; e.dbz = dbz; e.neg = neg; e.zro = zro; e.acc = 0;
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt = done_cnt + 1;
         if (sb_q.size() == 0) begin
            n_chk  = n_chk + 1;
            n_fail = n_fail + 1;
            $display("FAIL unexpected_done: done=1 with no outstanding op (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("quotient",    16'(quotient),    16'(e.q));
            chk("remainder",   16'(remainder),   16'(e.r));
            chk("overflow",    16'(overflow),    16'(e.ovf));
            chk("div_by_zero", 16'(div_by_zero), 16'(e.dbz));
            chk("negative",    16'(negative),    16'(e.neg));
            chk("zero",        16'(zero),        16'(e.zro));
            chk("busy_at_done", 16'(busy),       16'd0);
            chk("latency",     16'(cyc - e.acc), 16'd17);
         end
      end
   end

   // Call at a negedge; asserts start for one edge and returns at the following negedge.
   task automatic issue(input exp_t e, input bit push);
      exp_t t;
      t = e;
      dividend = e.dvd;
      divisor  = e.dvs;
      div_sel  = e.sel;
      start    = 1'b1;
      t.acc    = cyc + 1;
      if (push) sb_q.push_back(t);
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_chk  = n_chk + 1;
         n_fail = n_fail + 1;
         $display("FAIL done_timeout: no done within %0d cycles", budget);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_quotient"},    16'(quotient),    16'd0);
      chk({tag, "_remainder"},   16'(remainder),   16'd0);
      chk({tag, "_busy"},        16'(busy),        16'd0);
      chk({tag, "_done"},        16'(done),        16'd0);
      chk({tag, "_flags"},       16'({overflow, div_by_zero, negative, zero}), 16'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int dc;
      rst_n    = 1'b0;
      start    = 1'b0;
      div_sel  = 1'b0;
      dividend = '0;
      divisor  = '0;

      // Directed vectors: dividend, divisor, sel, q, r, ovf, dbz, neg, zero
      vec.push_back(mk(16'd1000, 8'd7,  1'b0, 8'd142, 8'd6,  1'b0, 1'b0, 1'b0, 1'b0));
      vec.push_back(mk(16'hFF9C, 8'h07, 1'b1, 8'hF2,  8'hFE, 1'b0, 1'b0, 1'b1, 1'b0));
      vec.push_back(mk(16'hFC00, 8'h08, 1'b1, 8'h80,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
      vec.push_back(mk(16'h1234, 8'h10, 1'b0, 8'h23,  8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
      vec.push_back(mk(16'h8000, 8'h80, 1'b1, 8'h00,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1));
      vec.push_back(mk(16'h00AB, 8'h00, 1'b0, 8'hFF,  8'hAB, 1'b0, 1'b1, 1'b0, 1'b0));
      vec.push_back(mk(16'h00AB, 8'h00, 1'b1, 8'hFF,  8'hAB, 1'b0, 1'b1, 1'b1, 1'b0));
      vec.push_back(mk(16'hFFFF, 8'hFF, 1'b0, 8'h01,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
      vec.push_back(mk(16'h00FF, 8'h01, 1'b0, 8'hFF,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
      vec.push_back(mk(16'h0064, 8'hF9, 1'b1, 8'hF2,  8'h02, 1'b0, 1'b0, 1'b1, 1'b0));
      vec.push_back(mk(16'hFF9C, 8'hF9, 1'b1, 8'h0E,  8'hFE, 1'b0, 1'b0, 1'b0, 1'b0));
      vec.push_back(mk(16'h0005, 8'h07, 1'b1, 8'h00,  8'h05, 1'b0, 1'b0, 1'b0, 1'b1));
      vec.push_back(mk(16'h0080, 8'h01, 1'b1, 8'h80,  8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
      vec.push_back(mk(16'hFF80, 8'h01, 1'b1, 8'h80,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
      vec.push_back(mk(16'h8000, 8'hFF, 1'b1, 8'h00,  8'h00, 1'b1, 1'b0, 1'b0, 1'b1));

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Independent operations with an idle gap between them
      foreach (vec[i]) begin
         issue(vec[i], 1'b1);
         chk("busy_in_flight", 16'(busy), 16'd1);
         wait_done(40);
         @(negedge clk);
      end

      // Start pulsed mid-operation is ignored: only one done follows
      dc = done_cnt;
      issue(mk(16'd1000, 8'd7, 1'b0, 8'd142, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
      repeat (4) @(negedge clk);
      issue(mk(16'h0010, 8'h02, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
      wait_done(40);
      // Back-to-back: new start in the done cycle
      issue(mk(16'hFF9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
      wait_done(40);
      repeat (25) @(negedge clk);
      chk("done_pulses", 16'(done_cnt - dc), 16'd2);
      chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);

      // Reset mid-operation clears everything and no stale done follows
      issue(mk(16'h1234, 8'h10, 1'b0, 8'h23, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_all_zero("midop_reset");
      dc = done_cnt;
      repeat (30) @(negedge clk);
      chk("no_stale_done", 16'(done_cnt - dc), 16'd0);
      chk("idle_after_reset", 16'(busy), 16'd0);

      // Divider still works after the abort
      issue(mk(16'd1000, 8'd7, 1'b0, 8'd142, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
      wait_done(40);
      @(negedge clk);
      chk("final_drained", 16'(sb_q.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
